// File: rtl/inst_dispatch_latch.sv
// Dispatch latch between the instruction buffer and rename: registers one 4-wide group per cycle.
// Optional branch-checkpoint gating is compiled in with macro BRANCH_CKPT_CHECK_EN.

module inst_dispatch_latch_chk #(
  parameter int CKPT_NUM     = 8,
  parameter int CKPT_LOG     = 3,
  parameter int BRANCH_COUNT = 3,
  parameter bit GATED        = 1'b1
) (
  input logic                    clk,
  input logic                    reset,
  input logic                    take,
  input logic [BRANCH_COUNT-1:0] branch_count,
  input logic [CKPT_LOG:0]       free_ckpt
);

  // A taken group must never consume more checkpoints than are free.
  no_ckpt_underflow: assert property (@(posedge clk) disable iff (!reset)
    !(GATED && take && (32'(branch_count) > 32'(free_ckpt))));

  free_ckpt_in_range: assert property (@(posedge clk) disable iff (!reset)
    (32'(free_ckpt) <= 32'(CKPT_NUM)));

endmodule

module inst_dispatch_latch #(
  parameter int PKT_W        = 64,
  parameter int CKPT_NUM     = 8,
  parameter int CKPT_LOG     = 3,
  parameter int BRANCH_COUNT = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush_i,
  input  logic                    instBufferReady_i,
  input  logic [PKT_W-1:0]        decodedPacket0_i,
  input  logic [PKT_W-1:0]        decodedPacket1_i,
  input  logic [PKT_W-1:0]        decodedPacket2_i,
  input  logic [PKT_W-1:0]        decodedPacket3_i,
  input  logic [BRANCH_COUNT-1:0] branchCount_i,
  input  logic                    stall_i,
  input  logic [CKPT_LOG:0]       ckptFree_i,
  output logic                    stallBuffer_o,
  output logic                    dispatchValid_o,
  output logic [PKT_W-1:0]        decodedPacket0_o,
  output logic [PKT_W-1:0]        decodedPacket1_o,
  output logic [PKT_W-1:0]        decodedPacket2_o,
  output logic [PKT_W-1:0]        decodedPacket3_o,
  output logic [BRANCH_COUNT-1:0] branchCount_o,
  output logic [CKPT_LOG:0]       freeCkpt_o
);

  localparam int CW = CKPT_LOG + 2;
  localparam logic [CKPT_LOG:0] CKPT_FULL = (CKPT_LOG+1)'(CKPT_NUM);

  logic                    take_s;
  logic                    ckpt_block_s;
  logic                    valid_q, valid_d;
  logic [PKT_W-1:0]        pkt0_q, pkt0_d;
  logic [PKT_W-1:0]        pkt1_q, pkt1_d;
  logic [PKT_W-1:0]        pkt2_q, pkt2_d;
  logic [PKT_W-1:0]        pkt3_q, pkt3_d;
  logic [BRANCH_COUNT-1:0] bcnt_q, bcnt_d;
  logic [CKPT_LOG:0]       free_s;

  assign stallBuffer_o = (valid_q & stall_i) | ckpt_block_s;
  assign take_s        = instBufferReady_i & ~stallBuffer_o & ~flush_i;

`ifdef BRANCH_CKPT_CHECK_EN
  logic [CKPT_LOG:0] free_q, free_d;
  logic [CW-1:0]     free_sum_s;

  // Consume on take and credit releases in the same cycle, saturating at the machine total.
  always_comb begin
    ckpt_block_s = (CW'(branchCount_i) > CW'(free_q));
    free_sum_s   = CW'(free_q) - (take_s ? CW'(branchCount_i) : {CW{1'b0}}) + CW'(ckptFree_i);
    if (free_sum_s > CW'(CKPT_NUM)) begin
      free_d = CKPT_FULL;
    end else begin
      free_d = free_sum_s[CKPT_LOG:0];
    end
  end

  // Free checkpoint counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      free_q <= CKPT_FULL;
    end else begin
      free_q <= free_d;
    end
  end

  assign free_s = free_q;
`else
  logic unused_ckpt_free_s;

  assign ckpt_block_s       = 1'b0;
  assign free_s             = CKPT_FULL;
  assign unused_ckpt_free_s = ^ckptFree_i;
`endif

  // Group latch: flush beats stall, a take loads, a stalled valid group holds, otherwise drain.
  always_comb begin
    valid_d = valid_q;
    pkt0_d  = pkt0_q;
    pkt1_d  = pkt1_q;
    pkt2_d  = pkt2_q;
    pkt3_d  = pkt3_q;
    bcnt_d  = bcnt_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (take_s) begin
      valid_d = 1'b1;
      pkt0_d  = decodedPacket0_i;
      pkt1_d  = decodedPacket1_i;
      pkt2_d  = decodedPacket2_i;
      pkt3_d  = decodedPacket3_i;
      bcnt_d  = branchCount_i;
    end else if (valid_q && stall_i) begin
      valid_d = valid_q;
    end else begin
      valid_d = 1'b0;
    end
  end

  // Output group registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      pkt0_q  <= {PKT_W{1'b0}};
      pkt1_q  <= {PKT_W{1'b0}};
      pkt2_q  <= {PKT_W{1'b0}};
      pkt3_q  <= {PKT_W{1'b0}};
      bcnt_q  <= {BRANCH_COUNT{1'b0}};
    end else begin
      valid_q <= valid_d;
      pkt0_q  <= pkt0_d;
      pkt1_q  <= pkt1_d;
      pkt2_q  <= pkt2_d;
      pkt3_q  <= pkt3_d;
      bcnt_q  <= bcnt_d;
    end
  end

  assign dispatchValid_o  = valid_q;
  assign decodedPacket0_o = pkt0_q;
  assign decodedPacket1_o = pkt1_q;
  assign decodedPacket2_o = pkt2_q;
  assign decodedPacket3_o = pkt3_q;
  assign branchCount_o    = bcnt_q;
  assign freeCkpt_o       = free_s;

  inst_dispatch_latch_chk #(
    .CKPT_NUM     (CKPT_NUM),
    .CKPT_LOG     (CKPT_LOG),
    .BRANCH_COUNT (BRANCH_COUNT),
`ifdef BRANCH_CKPT_CHECK_EN
    .GATED        (1'b1)
`else
    .GATED        (1'b0)
`endif
  ) u_chk (
    .clk          (clk),
    .reset        (reset),
    .take         (take_s),
    .branch_count (branchCount_i),
    .free_ckpt    (free_s)
  );

endmodule

// File: doc/inst_dispatch_latch.md
INST_DISPATCH_LATCH -- requirements
Module: inst_dispatch_latch

Interface
REQ-001 The block SHALL have parameter PKT_W, default = decoded-packet width (2*SIZE_SPECIAL_REG+…+SIZE_CTI_LOG+1), meaning the width of one decoded packet.
REQ-002 The block SHALL have parameter CKPT_NUM, default 8, meaning the number of branch checkpoints in the machine.
REQ-003 The block SHALL have parameter CKPT_LOG, default 3, meaning log2(CKPT_NUM); the free counter is CKPT_LOG+1 bits wide.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the posedge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port flush_i, input, 1 bit: control-mispredict flush.
REQ-007 The block SHALL have port instBufferReady_i, input, 1 bit: the instruction buffer holds at least DISPATCH_WIDTH (4) packets.
REQ-008 The block SHALL have ports decodedPacket0_i..decodedPacket3_i, input, PKT_W bits each: the head group from the instruction buffer.
REQ-009 The block SHALL have port branchCount_i, input, BRANCH_COUNT bits: the number of branches in the head group.
REQ-010 The block SHALL have port stall_i, input, 1 bit: rename/issue/active list cannot accept a group.
REQ-011 The block SHALL have port ckptFree_i, input, CKPT_LOG+1 bits: checkpoints released by the backend this cycle.
REQ-012 The block SHALL have port stallBuffer_o, output, 1 bit: stall to the instruction buffer; the head must not advance while it is high.
REQ-013 The block SHALL have port dispatchValid_o, output, 1 bit: the output group is valid.
REQ-014 The block SHALL have ports decodedPacket0_o..decodedPacket3_o, output, PKT_W bits each: the registered group.
REQ-015 The block SHALL have port branchCount_o, output, BRANCH_COUNT bits: the registered branch count of the group.
REQ-016 The block SHALL have port freeCkpt_o, output, CKPT_LOG+1 bits: the current free checkpoint count.

Function
REQ-017 The block SHALL define a take condition: take = instBufferReady_i & ~stallBuffer_o & ~flush_i.
REQ-018 The block SHALL compute stallBuffer_o combinationally as (dispatchValid_o & stall_i) | (branchCount_i > freeCkpt_o).
REQ-019 On take, the block SHALL register all four packets and branchCount_i on the next posedge and set dispatchValid_o=1, giving 1-cycle latency.
REQ-020 When dispatchValid_o=1 & stall_i=1, the block SHALL hold outputs unchanged.
REQ-021 When ~stall_i & ~take, the block SHALL clear dispatchValid_o; packet registers MAY hold stale data.
REQ-022 Back-to-back takes SHALL occur every cycle while ready, unstalled, and sufficient checkpoints are available.
REQ-023 The block SHALL update freeCkpt as freeCkpt - (take ? branchCount_i : 0) + ckptFree_i in one cycle, both terms applied simultaneously.
REQ-024 freeCkpt SHALL saturate at CKPT_NUM; underflow is impossible by REQ-018, and the block SHALL assert this in simulation.
REQ-025 freeCkpt == branchCount_i SHALL be allowed, and the group SHALL be taken, leaving 0 free.
REQ-026 On flush_i, the block SHALL clear dispatchValid_o next cycle, take nothing, and still apply ckptFree_i.
REQ-027 flush_i SHALL have priority over stall_i.

Reset
REQ-028 While reset=0, the block SHALL asynchronously force dispatchValid_o=0, branchCount_o=0, all packet outputs=0, and freeCkpt_o=CKPT_NUM.
REQ-029 Reset asserted mid-group SHALL discard the group; no take occurs in the release cycle unless the take conditions hold at the first posedge after release.

Configuration
REQ-030 The block SHALL support macro BRANCH_CKPT_CHECK_EN.
REQ-031 With BRANCH_CKPT_CHECK_EN defined, the checkpoint counter and the gating term in REQ-018 SHALL be present.
REQ-032 Without BRANCH_CKPT_CHECK_EN, stallBuffer_o SHALL equal dispatchValid_o & stall_i, freeCkpt_o SHALL be tied to CKPT_NUM, and ckptFree_i SHALL be ignored.

Verification
REQ-033 The bench SHALL cover: reset low, then release; ready=1, branchCount=0 -> dispatchValid_o=1 one cycle later, packets match, freeCkpt_o=8.
REQ-034 The bench SHALL cover: valid group with stall_i=1 for 3 cycles -> outputs stable, stallBuffer_o=1; stall drops -> next group latched the following cycle.
REQ-035 The bench SHALL cover: freeCkpt=2, branchCount_i=3 -> stallBuffer_o=1, no take; ckptFree_i=1 -> take next cycle, freeCkpt_o=0.
REQ-036 The bench SHALL cover: freeCkpt=7, take with branchCount_i=0 and ckptFree_i=3 -> freeCkpt_o=8 (saturated).
REQ-037 The bench SHALL cover: flush_i with stall_i=1 and valid group -> dispatchValid_o=0 next cycle, ckptFree_i=2 still credited.
REQ-038 The bench SHALL cover: build without BRANCH_CKPT_CHECK_EN, branchCount_i=4 every cycle -> take every cycle, freeCkpt_o=8 constant.
